// File: rtl/sysctrl_host_if.sv
// Requester and responder-bus signal bundle for the system-control byte initiator.
// master is the host's view; slave is the view of whoever requests and responds.
interface sysctrl_host_if #(
  parameter int LW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_cmd;
  logic [LW-1:0] req_len;
  logic          tx_take;
  logic [7:0]    tx_data;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [LW-1:0] rx_index;
  logic          done;
  logic          busy;
  logic          bus_strobe;
  logic          bus_start;
  logic [7:0]    bus_data;
  logic [7:0]    bus_din;

  modport master (
    input  req_valid, req_cmd, req_len, tx_data, bus_din,
    output req_ready, tx_take, rx_valid, rx_data, rx_index, done, busy,
           bus_strobe, bus_start, bus_data
  );

  modport slave (
    output req_valid, req_cmd, req_len, tx_data, bus_din,
    input  req_ready, tx_take, rx_valid, rx_data, rx_index, done, busy,
           bus_strobe, bus_start, bus_data
  );
endinterface

// File: rtl/sysctrl_host.sv
// FPGA-side initiator for the system-control byte protocol: start-flagged command
// strobe, then paced payload strobes, with one captured response byte per payload.
module sysctrl_host #(
  parameter int MAX_LEN = 16,
  parameter int GAP     = 2,
  parameter int LW      = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  sysctrl_host_if.master hif,
  input  logic           int_n,
  output logic           irq
);
  typedef enum logic [2:0] {IDLE, CMD, GAPW, BYTE, CAPT, EMIT, DONE} state_t;

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [3:0]    GAP_L     = 4'(GAP);
  // Capture and emit already space the strobes by three cycles, so the refill is shorter.
  localparam int            REGAP     = (GAP > 2) ? GAP - 2 : 0;
  localparam logic [3:0]    REGAP_L   = 4'(REGAP);

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [3:0]    gap_q, gap_d;
  logic [7:0]    bus_data_q, bus_data_d;
  logic [7:0]    samp_q, samp_d;
  logic [1:0]    sync_q, sync_d;

  logic          tx_take_c;
  logic          rx_valid_c;
  logic          done_c;
  logic          strobe_c;
  logic          start_c;
  logic [LW-1:0] len_clamp;

  assign len_clamp = (hif.req_len > MAX_LEN_L) ? MAX_LEN_L : hif.req_len;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    bus_data_d = bus_data_q;
    samp_d     = samp_q;
    tx_take_c  = 1'b0;
    rx_valid_c = 1'b0;
    done_c     = 1'b0;
    strobe_c   = 1'b0;
    start_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hif.req_valid) begin
          bus_data_d = hif.req_cmd;
          len_d      = len_clamp;
          idx_d      = '0;
          state_d    = CMD;
        end
      end
      CMD: begin
        strobe_c = 1'b1;
        start_c  = 1'b1;
        gap_d    = GAP_L;
        state_d  = GAPW;
      end
      GAPW: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          if (idx_q == len_q) begin
            state_d = DONE;
          end else begin
            tx_take_c  = 1'b1;
            bus_data_d = hif.tx_data;
            state_d    = BYTE;
          end
        end
      end
      BYTE: begin
        strobe_c = 1'b1;
        state_d  = CAPT;
      end
      CAPT: begin
        samp_d  = hif.bus_din;
        state_d = EMIT;
      end
      EMIT: begin
        rx_valid_c = 1'b1;
        if (idx_q == len_q - LW'(1)) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + LW'(1);
          // With no refill wait, the next payload byte is taken here instead of in GAPW.
          if (REGAP == 0) begin
            tx_take_c  = 1'b1;
            bus_data_d = hif.tx_data;
            state_d    = BYTE;
          end else begin
            gap_d   = REGAP_L;
            state_d = GAPW;
          end
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sync_d = {sync_q[0], ~int_n};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      bus_data_q <= '0;
      samp_q     <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      bus_data_q <= bus_data_d;
      samp_q     <= samp_d;
      sync_q     <= sync_d;
    end
  end

  // Strobe and start decode straight from the state flop so reset drops them at once.
  assign hif.req_ready  = (state_q == IDLE);
  assign hif.busy       = (state_q != IDLE);
  assign hif.tx_take    = tx_take_c;
  assign hif.rx_valid   = rx_valid_c;
  assign hif.rx_data    = samp_q;
  assign hif.rx_index   = idx_q;
  assign hif.done       = done_c;
  assign hif.bus_strobe = strobe_c;
  assign hif.bus_start  = start_c;
  assign hif.bus_data   = bus_data_q;
  assign irq            = sync_q[1];
endmodule

// File: tb/tb_sysctrl_host.sv
// Self-checking bench for sysctrl_host: table of transactions against a small
// responder model, plus hand sequences for mid-transaction reset and interrupt sync.
module tb_sysctrl_host;
  localparam int LW = 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic int_n   = 1'b1;
  logic irq;

  sysctrl_host_if #(.LW(LW)) bif ();

  sysctrl_host #(.MAX_LEN(16), .GAP(2), .LW(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hif     (bif.master),
    .int_n   (int_n),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder model: cmd 0x00 returns an ID string, 0x02 is a colour register file
  // returning the old value, anything else echoes the inverted payload byte.
  logic [7:0] r_cmd = 8'h00;
  logic [4:0] r_ptr = 5'd0;
  logic [7:0] colour [4] = '{default: 8'h00};

  function automatic logic [7:0] id_byte(input logic [4:0] p);
    case (p)
      5'd0:    return 8'h5C;
      5'd1:    return 8'h42;
      5'd2:    return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bif.bus_strobe) begin
      if (bif.bus_start) begin
        r_cmd <= bif.bus_data;
        r_ptr <= 5'd0;
      end else begin
        r_ptr <= r_ptr + 5'd1;
        case (r_cmd)
          8'h00: bif.bus_din <= id_byte(r_ptr);
          8'h02: begin
            bif.bus_din           <= colour[r_ptr[1:0]];
            colour[r_ptr[1:0]]    <= bif.bus_data;
          end
          default: bif.bus_din <= ~bif.bus_data;
        endcase
      end
    end
  end

  // Payload source
  logic [7:0] tx_vec [32];
  int take_total = 0;
  int tx_base    = 0;
  always @(posedge clk) if (bif.tx_take) take_total <= take_total + 1;
  assign bif.tx_data = tx_vec[(take_total - tx_base) & 31];

  // Event monitor
  int         n_str = 0, n_rx = 0, n_done = 0, n_take = 0, viol = 0;
  int         str_cyc   [512];
  logic       str_start [512];
  logic [7:0] str_data  [512];
  int         rx_cyc    [512];
  logic [7:0] rx_dat    [512];
  logic [4:0] rx_idx    [512];
  int         done_cyc  [512];
  int         take_cyc  [512];
  logic       prev_str = 1'b0;

  always @(negedge clk) begin
    if (bif.bus_strobe) begin
      str_cyc[n_str & 511]   <= cyc;
      str_start[n_str & 511] <= bif.bus_start;
      str_data[n_str & 511]  <= bif.bus_data;
      n_str <= n_str + 1;
    end
    if ((bif.bus_start && !bif.bus_strobe) || (bif.bus_strobe && prev_str))
      viol <= viol + 1;
    prev_str <= bif.bus_strobe;
    if (bif.rx_valid) begin
      rx_cyc[n_rx & 511] <= cyc;
      rx_dat[n_rx & 511] <= bif.rx_data;
      rx_idx[n_rx & 511] <= bif.rx_index;
      n_rx <= n_rx + 1;
    end
    if (bif.done) begin
      done_cyc[n_done & 511] <= cyc;
      n_done <= n_done + 1;
    end
    if (bif.tx_take) begin
      take_cyc[n_take & 511] <= cyc;
      n_take <= n_take + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]      cmd;
    logic [4:0]      len;
    int              n;
    logic [0:3][7:0] tx;
    logic [0:3][7:0] rx;
  } vec_t;

  vec_t vecs [7];

  // Runs one transaction starting in the current cycle and checks it with GAP=2 timing.
  task automatic apply_vec(input vec_t v);
    int t0, b_str, b_rx, b_done, b_take, exp_done;
    bit got;
    logic [7:0] exp_rx;
    for (int k = 0; k < 32; k++) tx_vec[k] = (k < 4) ? v.tx[k] : 8'(k * 3 + 1);
    b_str = n_str; b_rx = n_rx; b_done = n_done; b_take = n_take;
    tx_base = take_total;
    exp_done = (v.n == 0) ? 4 : 3 * v.n + 3;
    bif.req_cmd   = v.cmd;
    bif.req_len   = v.len;
    bif.req_valid = 1'b1;
    t0 = cyc;
    chk("accept_ready", 32'(bif.req_ready), 32'd1);
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk); #1;
      if (n_done != b_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("done_cycle", 32'(done_cyc[b_done & 511] - t0), 32'(exp_done));
      chk("ready_in_done", 32'(bif.req_ready), 32'd0);
      chk("busy_in_done", 32'(bif.busy), 32'd1);
    end
    @(negedge clk); #1;
    chk("ready_after_done", 32'(bif.req_ready), 32'd1);
    chk("busy_idle", 32'(bif.busy), 32'd0);
    chk("done_count", 32'(n_done - b_done), 32'd1);
    chk("strobe_count", 32'(n_str - b_str), 32'(v.n + 1));
    chk("cmd_start", 32'(str_start[b_str & 511]), 32'd1);
    chk("cmd_data", 32'(str_data[b_str & 511]), 32'(v.cmd));
    chk("cmd_cycle", 32'(str_cyc[b_str & 511] - t0), 32'd1);
    for (int k = 1; k <= v.n && k < n_str - b_str + 1; k++) begin
      chk("pay_start", 32'(str_start[(b_str + k) & 511]), 32'd0);
      chk("pay_data", 32'(str_data[(b_str + k) & 511]), 32'(tx_vec[k - 1]));
      chk("pay_cycle", 32'(str_cyc[(b_str + k) & 511] - t0), 32'(1 + 3 * k));
    end
    chk("take_count", 32'(n_take - b_take), 32'(v.n));
    if (v.n > 0 && n_take != b_take)
      chk("take_first_cycle", 32'(take_cyc[b_take & 511] - t0), 32'd3);
    chk("rx_count", 32'(n_rx - b_rx), 32'(v.n));
    for (int k = 0; k < v.n && k < n_rx - b_rx; k++) begin
      exp_rx = (k < 4) ? v.rx[k] : ~tx_vec[k];
      chk("rx_data", 32'(rx_dat[(b_rx + k) & 511]), 32'(exp_rx));
      chk("rx_index", 32'(rx_idx[(b_rx + k) & 511]), 32'(k));
      chk("rx_cycle", 32'(rx_cyc[(b_rx + k) & 511] - t0), 32'(6 + 3 * k));
    end
    chk("bus_data_hold", 32'(bif.bus_data), 32'((v.n == 0) ? v.cmd : tx_vec[v.n - 1]));
    $display("txn cmd=%02h len=%0d strobes=%0d rx=%0d t0=%0d", v.cmd, v.len,
             n_str - b_str, n_rx - b_rx, t0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, b_done;
    vecs[0] = '{cmd: 8'h00, len: 5'd3,  n: 3,  tx: '{8'h00, 8'h00, 8'h00, 8'h00}, rx: '{8'h5C, 8'h42, 8'h00, 8'h00}};
    vecs[1] = '{cmd: 8'h02, len: 5'd3,  n: 3,  tx: '{8'h80, 8'h40, 8'h20, 8'h00}, rx: '{8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{cmd: 8'h02, len: 5'd3,  n: 3,  tx: '{8'h11, 8'h22, 8'h33, 8'h00}, rx: '{8'h80, 8'h40, 8'h20, 8'h00}};
    vecs[3] = '{cmd: 8'h07, len: 5'd2,  n: 2,  tx: '{8'hA5, 8'h0F, 8'h00, 8'h00}, rx: '{8'h5A, 8'hF0, 8'h00, 8'h00}};
    vecs[4] = '{cmd: 8'h00, len: 5'd1,  n: 1,  tx: '{8'h00, 8'h00, 8'h00, 8'h00}, rx: '{8'h5C, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{cmd: 8'h01, len: 5'd0,  n: 0,  tx: '{8'h00, 8'h00, 8'h00, 8'h00}, rx: '{8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{cmd: 8'h05, len: 5'd31, n: 16, tx: '{8'h01, 8'h04, 8'h07, 8'h0A}, rx: '{8'hFE, 8'hFB, 8'hF8, 8'hF5}};

    for (int k = 0; k < 32; k++) tx_vec[k] = 8'h00;
    bif.req_valid = 1'b0;
    bif.req_cmd   = 8'h00;
    bif.req_len   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_strobe", 32'(bif.bus_strobe), 32'd0);
    chk("rst_start", 32'(bif.bus_start), 32'd0);
    chk("rst_take", 32'(bif.tx_take), 32'd0);
    chk("rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_bus_data", 32'(bif.bus_data), 32'd0);
    chk("rst_rx_data", 32'(bif.rx_data), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bif.req_ready), 32'd1);

    // Table, back-to-back: each transaction is presented the cycle after the previous done
    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i]);
      if (i == 1) begin
        chk("colour0", 32'(colour[0]), 32'h80);
        chk("colour1", 32'(colour[1]), 32'h40);
        chk("colour2", 32'(colour[2]), 32'h20);
      end
    end

    // Reset during the second payload strobe (cycle 7 after accept)
    for (int k = 0; k < 32; k++) tx_vec[k] = 8'h00;
    tx_base = take_total;
    bif.req_cmd   = 8'h00;
    bif.req_len   = 5'd3;
    bif.req_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    for (int w = 0; w < 20 && cyc != t0 + 7; w++) begin
      @(posedge clk); #1;
    end
    chk("strobe_before_rst", 32'(bif.bus_strobe), 32'd1);
    b_done = n_done;
    #1 reset_n = 1'b0;
    #1;
    chk("strobe_async_drop", 32'(bif.bus_strobe), 32'd0);
    chk("start_async_drop", 32'(bif.bus_start), 32'd0);
    chk("busy_async_drop", 32'(bif.busy), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_midrst", 32'(bif.req_ready), 32'd1);
    chk("no_done_on_rst", 32'(n_done - b_done), 32'd0);
    $display("txn reset mid-transaction at t0+7, done pulses=%0d", n_done - b_done);
    apply_vec(vecs[0]);

    // Interrupt synchroniser while a transaction is in flight
    fork
      apply_vec(vecs[3]);
      begin
        @(posedge clk); #3;
        int_n = 1'b0;
        @(posedge clk); #1;
        chk("irq_after_1edge", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_after_2edges", 32'(irq), 32'd1);
        repeat (3) @(posedge clk);
        #4 int_n = 1'b1;
        @(posedge clk); #1;
        chk("irq_hold_1edge", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_clear_2edges", 32'(irq), 32'd0);
        $display("irq toggle sequence complete");
      end
    join

    chk("bus_rules", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sysctrl_host.md
Name: sysctrl_host

Overview:
- FPGA-side initiator for the MCU system-control byte protocol: start-flagged command byte, then paced payload bytes on a strobe; the responder answers with a registered return byte per strobe.
- Used in MCU-less builds and self-test configurations where local fabric logic must drive the system control responder directly (boot config, LED/colour, interrupt service).
- Executes one command transaction per request and returns response bytes as a stream.

Parameters:
- MAX_LEN, 16, maximum payload bytes per transaction (excluding command byte).
- GAP, 2, idle cycles between consecutive bus strobes (legal range 1..15).
- LW, 5, width of req_len; must satisfy 2^LW > MAX_LEN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  high only in IDLE; accept = req_valid && req_ready.
- req_cmd  in  8  command byte.
- req_len  in  LW  payload byte count, 0..MAX_LEN.
- tx_take  out  1  one-cycle pulse: tx_data sampled this cycle for the next payload strobe.
- tx_data  in  8  payload byte supplied by requester.
- rx_valid  out  1  one-cycle pulse per response byte.
- rx_data  out  8  response byte.
- rx_index  out  LW  payload index of rx_data (0-based).
- done  out  1  one-cycle pulse at transaction end.
- busy  out  1  high from accept until done inclusive.
- bus_strobe  out  1  byte strobe to responder (1-cycle).
- bus_start  out  1  start flag, only with command-byte strobe.
- bus_data  out  8  byte to responder.
- bus_din  in  8  responder's registered return byte.
- int_n  in  1  responder interrupt, active low, asynchronous to clk.
- irq  out  1  synchronised interrupt level (high = pending).

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; req_ready=1 after release; all other outputs 0; irq sync chain cleared to 0 (no interrupt).
- FSM states: IDLE, CMD, GAPW, BYTE, CAPT, EMIT, DONE.
- IDLE: on accept, latch cmd and clamped len (req_len > MAX_LEN -> MAX_LEN); go to CMD. req_valid ignored in all other states.
- CMD (1 cycle): bus_strobe=1, bus_start=1, bus_data=cmd. Load gap counter with GAP; go to GAPW.
- GAPW: count down GAP cycles. If remaining bytes = 0, go to DONE. Otherwise assert tx_take in the last GAPW cycle, register tx_data into bus_data, then go to BYTE.
- BYTE (1 cycle): bus_strobe=1, bus_start=0, bus_data=latched tx byte.
- CAPT (1 cycle): sample bus_din; this is the responder value updated at the BYTE edge.
- EMIT (1 cycle): rx_valid=1, rx_data=sample, rx_index=i. If i is the last index, assert done in the same cycle and go to IDLE. Otherwise increment i, reload gap counter with GAP-2 (minimum 0, so strobe spacing stays at least GAP+1) and go to GAPW.
- Timing, GAP=2, len>=1, accept at cycle 0:
  - CMD strobe cycle 1.
  - tx_take cycle 3; payload0 strobe cycle 4.
  - rx_valid idx0 cycle 6.
  - Subsequent payload strobes every max(GAP+1, 3) cycles.
- len=0: DONE state pulses done GAP+1 cycles after the CMD strobe; no tx_take and no rx_valid occur.
- bus_start is never high without bus_strobe. bus_strobe never high on two consecutive cycles.
- bus_data holds its last value between strobes.
- busy = !IDLE. req_ready=0 during done cycle; back-to-back accept is possible the cycle after done.
- irq = int_n inverted through a 2-FF synchroniser; latency 2 clk edges. Independent of the FSM and not cleared by the host.
- Reset asserted mid-transaction: immediate return to IDLE; bus_strobe/bus_start drop asynchronously; no done pulse. The responder sees a truncated command, which it tolerates; the next start resynchronises it.
- Arithmetic: index counter LW bits, no wrap because len <= MAX_LEN; gap counter 4 bits.

Test Plan:
- cmd=0x00, len=3, bench responder attached -> rx_data 0x5C,0x42,0x00 at idx 0,1,2; done with idx2; exactly 4 strobes, first with bus_start=1.
- cmd=0x02, len=3, tx 0x80,0x40,0x20 -> three tx_take pulses; bus_data per strobe matches; responder colour register updates accordingly; done once.
- GAP=2 timing, accept at cycle 0, len=2 -> strobes at cycles 1,4,7; rx_valid at 6,9; done at 9; req_ready back at 10.
- len=0, cmd=0x01 -> single start strobe; done at cycle 4 (GAP=2); no tx_take/rx_valid. req_len=31 with MAX_LEN=16 -> 16 payload strobes.
- reset_n low at the cycle of the 2nd payload strobe -> bus_strobe=0 within same cycle; no done; after release a cmd=0x00 len=3 transaction returns 0x5C,0x42,0x00.
- int_n toggled asynchronously -> irq follows inverted after 2 clk edges; unaffected by concurrent transactions.
